// File: rtl/proc_bus_arbiter.sv
// -----------------------------------------------------------------------------
// proc_bus_arbiter
//   Round-robin arbiter that shares the processor-side bus of the APB master
//   between NUM_REQ requesters (CPU core, DMA, debug port). One request is
//   accepted at a time. It is driven onto pb_* with a one-cycle pb_start, the
//   arbiter waits for pb_ready, then pulses rsp_done to the winner, together
//   with the read data.
//
//   Optional feature macro: PROC_BUS_ARB_TIMEOUT_EN
//     defined   : WAIT is bounded by TIMEOUT_CYCLES. On expiry the transfer
//                 ends with rsp_err=1 and rsp_rdata all-ones.
//     undefined : WAIT waits for pb_ready indefinitely, and rsp_err is 0.
//
// Ports
//   clk        : clock, rising edge
//   reset      : asynchronous, active-low
//   req_valid  : per-requester request
//   req_write  : per-requester direction (1 = write)
//   req_addr   : requester i at [i*ADDR_W +: ADDR_W] ({dev[7:6], mem[5:0]})
//   req_wdata  : requester i at [i*DATA_W +: DATA_W]
//   req_sel    : requester i at [i*SEL_W +: SEL_W]
//   req_grant  : one-hot, 1 cycle, the fields of that requester were captured
//   rsp_done   : one-hot, 1 cycle, the transfer has finished
//   rsp_rdata  : last read data, shared by all requesters
//   rsp_err    : valid with rsp_done, flags a timeout abort
//   pb_write, pb_addr, pb_wdata, pb_sel : registered processor-bus fields
//   pb_start   : 1-cycle start pulse to the APB master
//   pb_ready   : transfer-complete from the APB master
//   pb_rdata   : read data from the APB master
// -----------------------------------------------------------------------------
module proc_bus_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int ADDR_W         = 8,
  parameter int DATA_W         = 8,
  parameter int SEL_W          = 2,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_write,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  input  logic [NUM_REQ*SEL_W-1:0]  req_sel,
  output logic [NUM_REQ-1:0]        req_grant,
  output logic [NUM_REQ-1:0]        rsp_done,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      rsp_err,
  output logic                      pb_write,
  output logic [ADDR_W-1:0]         pb_addr,
  output logic [DATA_W-1:0]         pb_wdata,
  output logic [SEL_W-1:0]          pb_sel,
  output logic                      pb_start,
  input  logic                      pb_ready,
  input  logic [DATA_W-1:0]         pb_rdata
);

  localparam int IDX_W = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 4 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("proc_bus_arbiter: NUM_REQ must be 2..4 and TIMEOUT_CYCLES >= 1");
  end

  typedef enum logic [1:0] {IDLE, START, WAIT, RELEASE} state_t;

  state_t             state, state_d;
  logic [IDX_W-1:0]   last_winner;
  logic [IDX_W-1:0]   winner;
  logic [IDX_W-1:0]   pick;
  logic [IDX_W-1:0]   cand;
  logic               found;
  logic               wait_first;
  logic               take;
  logic               finish_ok;
  logic               finish_to;

  function automatic logic [NUM_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
    onehot      = '0;
    onehot[idx] = 1'b1;
  endfunction

  // Round-robin search starting just above the previous winner, with wrap.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = IDX_W'((int'(last_winner) + k) % NUM_REQ);
      if (!found && req_valid[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

`ifdef PROC_BUS_ARB_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TO_W-1:0] to_cnt;
  logic            to_hit;

  // to_cnt is 0 in the first WAIT cycle, so the limit lands on the
  // TIMEOUT_CYCLES-th WAIT cycle.
  assign to_hit = (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      to_cnt <= '0;
    end else if (state == START) begin
      to_cnt <= '0;
    end else if (state == WAIT) begin
      to_cnt <= to_cnt + TO_W'(1);
    end
  end
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  // pb_ready may still be high from the previous transfer in the first WAIT
  // cycle, so it only counts once wait_first has cleared.
  always_comb begin
    state_d   = state;
    take      = 1'b0;
    finish_ok = 1'b0;
    finish_to = 1'b0;
    case (state)
      IDLE: begin
        if (found) begin
          take    = 1'b1;
          state_d = START;
        end
      end
      START: state_d = WAIT;
      WAIT: begin
        if (!wait_first && pb_ready) begin
          finish_ok = 1'b1;
          state_d   = RELEASE;
        end
`ifdef PROC_BUS_ARB_TIMEOUT_EN
        else if (to_hit) begin
          finish_to = 1'b1;
          state_d   = RELEASE;
        end
`endif
      end
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered on the edge that enters the state they belong to.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_winner <= IDX_W'(NUM_REQ - 1);
      winner      <= '0;
      wait_first  <= 1'b0;
      req_grant   <= '0;
      rsp_done    <= '0;
      rsp_rdata   <= '0;
      pb_write    <= 1'b0;
      pb_addr     <= '0;
      pb_wdata    <= '0;
      pb_sel      <= '0;
      pb_start    <= 1'b0;
    end else begin
      req_grant  <= '0;
      rsp_done   <= '0;
      pb_start   <= 1'b0;
      wait_first <= (state == START);
      if (take) begin
        winner    <= pick;
        pb_write  <= req_write[pick];
        pb_addr   <= req_addr[pick*ADDR_W +: ADDR_W];
        pb_wdata  <= req_wdata[pick*DATA_W +: DATA_W];
        pb_sel    <= req_sel[pick*SEL_W +: SEL_W];
        pb_start  <= 1'b1;
        req_grant <= onehot(pick);
      end
      if (finish_ok) begin
        rsp_done <= onehot(winner);
        pb_sel   <= '0;
        if (!pb_write) begin
          rsp_rdata <= pb_rdata;
        end
      end
      if (finish_to) begin
        rsp_done  <= onehot(winner);
        pb_sel    <= '0;
        rsp_rdata <= '1;
      end
      if (state == RELEASE) begin
        last_winner <= winner;
      end
    end
  end

`ifdef PROC_BUS_ARB_TIMEOUT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rsp_err <= 1'b0;
    end else begin
      rsp_err <= finish_to;
    end
  end
`else
  assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_proc_bus_arbiter.sv
module tb_proc_bus_arbiter;

  localparam int NR = 2;
  localparam int AW = 8;
  localparam int DW = 8;
  localparam int SW = 2;
  localparam int TO = 8;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic [NR-1:0]    req_valid = '0;
  logic [NR-1:0]    req_write = '0;
  logic [NR*AW-1:0] req_addr = '0;
  logic [NR*DW-1:0] req_wdata = '0;
  logic [NR*SW-1:0] req_sel = '0;
  logic [NR-1:0]    req_grant;
  logic [NR-1:0]    rsp_done;
  logic [DW-1:0]    rsp_rdata;
  logic             rsp_err;
  logic             pb_write;
  logic [AW-1:0]    pb_addr;
  logic [DW-1:0]    pb_wdata;
  logic [SW-1:0]    pb_sel;
  logic             pb_start;
  logic             pb_ready = 1'b0;
  logic [DW-1:0]    pb_rdata = '0;

  proc_bus_arbiter #(
    .NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .SEL_W(SW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_sel(req_sel),
    .req_grant(req_grant), .rsp_done(rsp_done), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err),
    .pb_write(pb_write), .pb_addr(pb_addr), .pb_wdata(pb_wdata),
    .pb_sel(pb_sel), .pb_start(pb_start),
    .pb_ready(pb_ready), .pb_rdata(pb_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NR-1:0] g;
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [SW-1:0] sel;
  } gexp_t;

  typedef struct {
    logic [NR-1:0] d;
    logic [DW-1:0] rdata;
    logic          err;
  } dexp_t;

  gexp_t         gq[$];
  dexp_t         dq[$];
  gexp_t         ge;
  dexp_t         de;
  int            n_vec = 0;
  int            n_err = 0;
  int            low_cnt = 0;
  logic [DW-1:0] model_rdata = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a grant or a done.
  always @(negedge clk) begin
    if (reset) begin
      chk("start_with_grant", {31'd0, pb_start}, {31'd0, |req_grant});
      if (|req_grant) begin
        if (gq.size() == 0) begin
          chk("unexpected_grant", {30'd0, req_grant}, 32'd0);
        end else begin
          ge = gq.pop_front();
          chk("grant", {30'd0, req_grant}, {30'd0, ge.g});
          chk("pb_write", {31'd0, pb_write}, {31'd0, ge.wr});
          chk("pb_addr", {24'd0, pb_addr}, {24'd0, ge.addr});
          chk("pb_wdata", {24'd0, pb_wdata}, {24'd0, ge.wdata});
          chk("pb_sel", {30'd0, pb_sel}, {30'd0, ge.sel});
          chk("sel_low_gap_ge2", {31'd0, low_cnt >= 2}, 32'd1);
        end
        low_cnt = 0;
      end
      if (|rsp_done) begin
        if (dq.size() == 0) begin
          chk("unexpected_done", {30'd0, rsp_done}, 32'd0);
        end else begin
          de = dq.pop_front();
          chk("done", {30'd0, rsp_done}, {30'd0, de.d});
          chk("rsp_rdata", {24'd0, rsp_rdata}, {24'd0, de.rdata});
          chk("rsp_err", {31'd0, rsp_err}, {31'd0, de.err});
        end
      end
    end
    if (pb_sel == '0) low_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input int i, input bit wr, input logic [7:0] a,
                           input logic [7:0] wd, input logic [1:0] s);
    req_valid[i]          = 1'b1;
    req_write[i]          = wr;
    req_addr[i*AW +: AW]  = a;
    req_wdata[i*DW +: DW] = wd;
    req_sel[i*SW +: SW]   = s;
  endtask

  task automatic push_g(input int i, input bit wr, input logic [7:0] a,
                        input logic [7:0] wd, input logic [1:0] s);
    gexp_t t;
    t.g = '0; t.g[i] = 1'b1;
    t.wr = wr; t.addr = a; t.wdata = wd; t.sel = s;
    gq.push_back(t);
  endtask

  task automatic push_d(input int i, input logic [7:0] rd, input bit err);
    dexp_t t;
    t.d = '0; t.d[i] = 1'b1;
    t.rdata = rd; t.err = err;
    dq.push_back(t);
  endtask

  task automatic wait_grant(input int i);
    bit got = 1'b0;
    int c = 0;
    while (!got && c < 20) begin
      @(negedge clk);
      got = req_grant[i];
      c++;
    end
    chk("grant_seen", {31'd0, got}, 32'd1);
  endtask

  task automatic wait_done(input int i);
    bit got = 1'b0;
    int c = 0;
    while (!got && c < 20) begin
      @(negedge clk);
      got = rsp_done[i];
      c++;
    end
    chk("done_seen", {31'd0, got}, 32'd1);
  endtask

  // Called at the START negedge. d = WAIT cycle after which pb_ready rises
  // (0: already in the first WAIT cycle, negative: never).
  task automatic serve(input int i, input int d, input int exp_lat);
    bit got = 1'b0;
    int c = 0;
    @(posedge clk);
    #1;
    req_valid[i] = 1'b0;
    if (d == 0) pb_ready = 1'b1;
    while (!got && c < 40) begin
      @(negedge clk);
      c++;
      got = rsp_done[i];
      if (!got && d > 0 && c == d) begin
        @(posedge clk);
        #1;
        pb_ready = 1'b1;
      end
    end
    chk("done_seen", {31'd0, got}, 32'd1);
    if (got) chk("done_latency", c, exp_lat);
    tick();
    pb_ready = 1'b0;
  endtask

  // Grant negedge -> done negedge: first WAIT ignored, so pb_ready counts
  // from the second WAIT cycle; done shows in RELEASE.
  function automatic int lat_of(input int d);
    return (d > 1) ? 3 + d - 1 : 3;
  endfunction

  task automatic xfer(input int i, input bit wr, input logic [7:0] a, input logic [7:0] wd,
                      input logic [1:0] s, input logic [7:0] rd, input int d);
    tick();
    drive_req(i, wr, a, wd, s);
    push_g(i, wr, a, wd, s);
    if (!wr) model_rdata = rd;
    push_d(i, model_rdata, 1'b0);
    pb_rdata = rd;
    wait_grant(i);
    serve(i, d, lat_of(d));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_req_grant", {30'd0, req_grant}, 32'd0);
    chk("rst_rsp_done", {30'd0, rsp_done}, 32'd0);
    chk("rst_rsp_rdata", {24'd0, rsp_rdata}, 32'd0);
    chk("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
    chk("rst_pb_write", {31'd0, pb_write}, 32'd0);
    chk("rst_pb_addr", {24'd0, pb_addr}, 32'd0);
    chk("rst_pb_wdata", {24'd0, pb_wdata}, 32'd0);
    chk("rst_pb_sel", {30'd0, pb_sel}, 32'd0);
    chk("rst_pb_start", {31'd0, pb_start}, 32'd0);
    tick();
    reset = 1'b1;

    // Contention from reset: order 0,1 then 0,1 again
    tick();
    drive_req(0, 1'b1, 8'h10, 8'hA0, 2'd1);
    drive_req(1, 1'b1, 8'h20, 8'hB0, 2'd2);
    push_g(0, 1'b1, 8'h10, 8'hA0, 2'd1); push_d(0, 8'h00, 1'b0);
    push_g(1, 1'b1, 8'h20, 8'hB0, 2'd2); push_d(1, 8'h00, 1'b0);
    wait_grant(0); serve(0, 0, 3);
    wait_grant(1); serve(1, 0, 3);
    drive_req(0, 1'b1, 8'h11, 8'hA1, 2'd3);
    drive_req(1, 1'b1, 8'h21, 8'hB1, 2'd1);
    push_g(0, 1'b1, 8'h11, 8'hA1, 2'd3); push_d(0, 8'h00, 1'b0);
    push_g(1, 1'b1, 8'h21, 8'hB1, 2'd1); push_d(1, 8'h00, 1'b0);
    wait_grant(0); serve(0, 1, 3);
    wait_grant(1); serve(1, 2, 4);

    // Single write, ready 3 cycles in; then read back
    xfer(0, 1'b1, 8'h41, 8'h05, 2'd1, 8'h00, 3);
    xfer(0, 1'b0, 8'h41, 8'h00, 2'd1, 8'h05, 0);

    // Stale pb_ready through START and the first WAIT cycle
    tick();
    pb_ready = 1'b1;
    drive_req(0, 1'b0, 8'h82, 8'h00, 2'd2);
    push_g(0, 1'b0, 8'h82, 8'h00, 2'd2);
    model_rdata = 8'h3C;
    push_d(0, 8'h3C, 1'b0);
    pb_rdata = 8'h3C;
    wait_grant(0);
    tick();
    req_valid[0] = 1'b0;
    tick();
    pb_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("stale_no_done", {30'd0, rsp_done}, 32'd0);
    end
    tick();
    pb_ready = 1'b1;
    wait_done(0);
    tick();
    pb_ready = 1'b0;

    // Reset in WAIT (last winner is 0, so without reset req1 would win next)
    tick();
    drive_req(1, 1'b1, 8'hC3, 8'h77, 2'd3);
    push_g(1, 1'b1, 8'hC3, 8'h77, 2'd3);
    wait_grant(1);
    tick();
    req_valid[1] = 1'b0;
    tick();
    reset = 1'b0;
    #1;
    chk("midrst_pb_sel", {30'd0, pb_sel}, 32'd0);
    chk("midrst_pb_start", {31'd0, pb_start}, 32'd0);
    chk("midrst_rsp_done", {30'd0, rsp_done}, 32'd0);
    chk("midrst_rsp_rdata", {24'd0, rsp_rdata}, 32'd0);
    chk("midrst_pb_addr", {24'd0, pb_addr}, 32'd0);
    model_rdata = 8'h00;
    drive_req(0, 1'b1, 8'h05, 8'h55, 2'd1);
    drive_req(1, 1'b1, 8'h45, 8'h66, 2'd2);
    push_g(0, 1'b1, 8'h05, 8'h55, 2'd1); push_d(0, 8'h00, 1'b0);
    push_g(1, 1'b1, 8'h45, 8'h66, 2'd2); push_d(1, 8'h00, 1'b0);
    repeat (2) tick();
    reset = 1'b1;
    wait_grant(0); serve(0, 0, 3);
    wait_grant(1); serve(1, 0, 3);

    // pb_ready never arrives
    tick();
    drive_req(0, 1'b0, 8'h55, 8'h00, 2'd1);
    push_g(0, 1'b0, 8'h55, 8'h00, 2'd1);
    pb_rdata = 8'h66;
`ifdef PROC_BUS_ARB_TIMEOUT_EN
    model_rdata = 8'hFF;
    push_d(0, 8'hFF, 1'b1);
    wait_grant(0);
    serve(0, -1, TO + 1);
`else
    model_rdata = 8'h66;
    push_d(0, 8'h66, 1'b0);
    wait_grant(0);
    tick();
    req_valid[0] = 1'b0;
    repeat (20) begin
      @(negedge clk);
      chk("wait_holds_no_done", {30'd0, rsp_done}, 32'd0);
    end
    chk("wait_holds_pb_sel", {30'd0, pb_sel}, 32'd1);
    tick();
    pb_ready = 1'b1;
    wait_done(0);
    tick();
    pb_ready = 1'b0;
`endif

    repeat (5) tick();
    chk("grant_queue_empty", gq.size(), 32'd0);
    chk("done_queue_empty", dq.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/proc_bus_arbiter.md
# proc_bus_arbiter

Round-robin arbiter that shares the single processor-side bus of the APB master between up to four requesters (CPU core, DMA, debug port). It accepts one request at a time and sequences the start/select handshake the APB master expects. It waits for APB completion, then returns read data and a done pulse to the winning requester. It sits directly in front of the APB master, which drives the APB slave with I2C peripheral.

## Interface
- NUM_REQ, 2, number of requesters (2..4)
- ADDR_W, 8, address width; bits [7:6] are the I2C device address, [5:0] the memory address
- DATA_W, 8, data width
- SEL_W, 2, slave-select width
- TIMEOUT_CYCLES, 64, WAIT-state limit, used only with the timeout feature
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low
- req_valid  in  NUM_REQ  per-requester request
- req_write  in  NUM_REQ  1 = write, 0 = read
- req_addr  in  NUM_REQ*ADDR_W  requester i at [i*ADDR_W +: ADDR_W]
- req_wdata  in  NUM_REQ*DATA_W  packed the same way
- req_sel  in  NUM_REQ*SEL_W  packed the same way
- req_grant  out  NUM_REQ  one-hot, 1-cycle: fields captured
- rsp_done  out  NUM_REQ  one-hot, 1-cycle: transfer finished
- rsp_rdata  out  DATA_W  last read data, shared
- rsp_err  out  1  valid with rsp_done: timeout abort
- pb_write, pb_addr, pb_wdata, pb_sel  out  1/ADDR_W/DATA_W/SEL_W  to processor bus
- pb_start  out  1  1-cycle start pulse
- pb_ready  in  1  APB ready from the master side
- pb_rdata  in  DATA_W  processor bus read data

## Operation
- FSM states: IDLE, START, WAIT, RELEASE.
- IDLE: if any req_valid is high, pick the winner round-robin, searching from last_winner+1 upward with wrap. Capture that requester's write/addr/wdata/sel into pb_* registers. Go to START.
- START: pb_start=1, pb_sel=captured sel, req_grant[winner]=1. Go to WAIT.
- WAIT: pb_start=0, all pb_* held. pb_ready is ignored in the first WAIT cycle and sampled from the second onward. When pb_ready=1: pulse rsp_done[winner]. On a read, rsp_rdata<=pb_rdata; on a write, rsp_rdata is unchanged. rsp_err=0. Go to RELEASE.
- RELEASE: pb_sel=0, last_winner<=winner. Go to IDLE.
- A requester deasserts req_valid after it sees its grant. A req_valid still high when the FSM returns to IDLE is a new request.
- A request that drops before it is granted is discarded with no side effects.
- Losing requesters wait with no timeout. Round-robin guarantees service within NUM_REQ transfers.

## Timing
- Reset values: state=IDLE, last_winner=NUM_REQ-1 (so requester 0 wins first). All outputs are 0, including pb_sel, pb_start, rsp_rdata and rsp_err.
- All outputs are registered.
- A request seen in IDLE at edge N produces START (grant and pb_start) in cycle N+1.
- Minimum transfer occupancy: START + 2 WAIT + RELEASE = 4 cycles.
- pb_sel is low for at least 2 cycles (RELEASE, IDLE) between back-to-back transfers.
- Reset mid-transfer: all outputs drop asynchronously to their reset values. No rsp_done is issued, and last_winner returns to NUM_REQ-1.
- If pb_ready is high in the first WAIT cycle (stale from the previous transfer), it is ignored.

## Configuration
- PROC_BUS_ARB_TIMEOUT_EN defined:
  - A counter clears on entry to WAIT and increments each WAIT cycle.
  - If it reaches TIMEOUT_CYCLES with no pb_ready, the arbiter pulses rsp_done[winner] with rsp_err=1, sets rsp_rdata=8'hFF, and goes to RELEASE.
  - If pb_ready arrives in the same cycle as the limit, it wins: the transfer completes normally with rsp_err=0.
- PROC_BUS_ARB_TIMEOUT_EN undefined: no counter is built, WAIT waits indefinitely, rsp_err is tied to 0, and TIMEOUT_CYCLES is unused.

## Test plan
- Single write: req0 write, addr 8'h41, wdata 5, sel 1. Expect pb_start for 1 cycle, pb_addr=8'h41, pb_wdata=5. pb_ready held 3 cycles later gives rsp_done[0] and rsp_err=0.
- Read back: req0 read, addr 8'h41, pb_rdata=5 at pb_ready. Expect rsp_rdata=5 together with rsp_done[0].
- Contention: req0 and req1 asserted in the same cycle from reset, then both re-request. Expect grant order 0,1,0,1, with pb_sel low for ≥2 cycles between transfers.
- Stale ready: pb_ready held high into START and the first WAIT cycle, then low. Expect no rsp_done until pb_ready rises again.
- Reset mid-WAIT: assert reset during WAIT. Expect immediate pb_sel=0, no rsp_done, and requester 0 granted first after release.
- Timeout (macro defined, TIMEOUT_CYCLES=8): pb_ready never asserted. Expect rsp_done with rsp_err=1 and rsp_rdata=8'hFF after 8 WAIT cycles. With the macro undefined, the FSM stays in WAIT.
